// File: rtl/shift_sequencer.sv
// ============================================================================
//  Module   : shift_sequencer
//  Brief    : Sequences one load-then-shift job on an external 8-bit
//             universal shift register and captures its final value.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_sequencer (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic       dir_i,
    input  logic [3:0] count_i,
    input  logic [7:0] load_data_i,
    input  logic       fill_i,
    input  logic [7:0] Y_i,
    output logic [1:0] S_o,
    output logic [7:0] data_o,
    output logic       data_L_o,
    output logic       data_R_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] result_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] c_S_HOLD  = 2'b00;
    localparam logic [1:0] c_S_RIGHT = 2'b01;
    localparam logic [1:0] c_S_LEFT  = 2'b10;
    localparam logic [1:0] c_S_LOAD  = 2'b11;
    localparam logic [3:0] c_MAX_CNT = 4'd8;

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_data;
    logic       r_dir;
    logic       r_fill;
    logic [3:0] r_count;
    logic       r_done;
    logic [7:0] r_result;
    logic [3:0] w_eff_count;

    // More than eight shifts cannot change an 8-bit value further.
    assign w_eff_count = (count_i > c_MAX_CNT) ? c_MAX_CNT : count_i;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start_i) w_next = ST_LOAD;
            ST_LOAD: begin
                if (abort_i)              w_next = ST_IDLE;
                else if (r_count != 4'd0) w_next = ST_SHIFT;
                else                      w_next = ST_DONE;
            end
            ST_SHIFT: begin
                if (abort_i)              w_next = ST_IDLE;
                else if (r_count == 4'd1) w_next = ST_DONE;
            end
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        S_o      = c_S_HOLD;
        data_L_o = 1'b0;
        data_R_o = 1'b0;
        case (r_state)
            ST_LOAD:  S_o = c_S_LOAD;
            ST_SHIFT: begin
                S_o      = r_dir ? c_S_RIGHT : c_S_LEFT;
                data_L_o = r_dir ? r_fill : 1'b0;
                data_R_o = r_dir ? 1'b0 : r_fill;
            end
            default:  S_o = c_S_HOLD;
        endcase
    end

    assign busy_o   = (r_state != ST_IDLE);
    assign data_o   = r_data;
    assign done_o   = r_done;
    assign result_o = r_result;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state  <= ST_IDLE;
            r_data   <= 8'h00;
            r_dir    <= 1'b0;
            r_fill   <= 1'b0;
            r_count  <= 4'd0;
            r_done   <= 1'b0;
            r_result <= 8'h00;
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == ST_DONE);
            if (r_state == ST_DONE) begin
                r_result <= Y_i;
            end
            if (r_state == ST_IDLE && start_i) begin
                r_data  <= load_data_i;
                r_dir   <= dir_i;
                r_fill  <= fill_i;
                r_count <= w_eff_count;
            end
            if (r_state == ST_SHIFT) begin
                r_count <= r_count - 4'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_shift_sequencer.sv
// ============================================================================
//  Module   : tb_shift_sequencer
//  Brief    : Directed bench for shift_sequencer with a behavioural shifter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       dir = 1'b0;
    logic [3:0] count = 4'd0;
    logic [7:0] load_data = 8'h00;
    logic       fill = 1'b0;
    logic [7:0] y = 8'h00;
    logic [1:0] s;
    logic [7:0] data;
    logic       data_l;
    logic       data_r;
    logic       busy;
    logic       done;
    logic [7:0] result;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] load;
        logic       dir;
        logic [3:0] count;
        logic       fill;
        logic [7:0] exp_result;
        int         exp_lat;
    } vec_t;

    vec_t vecs[6];

    shift_sequencer dut (
        .Clk        (clk),
        .Rst        (rst),
        .start_i    (start),
        .abort_i    (abort),
        .dir_i      (dir),
        .count_i    (count),
        .load_data_i(load_data),
        .fill_i     (fill),
        .Y_i        (y),
        .S_o        (s),
        .data_o     (data),
        .data_L_o   (data_l),
        .data_R_o   (data_r),
        .busy_o     (busy),
        .done_o     (done),
        .result_o   (result)
    );

    always #5 clk = ~clk;

    // Controlled universal shift register, updating on the same edge.
    always @(posedge clk) begin
        case (s)
            2'b11:   y <= data;
            2'b01:   y <= {data_l, y[7:1]};
            2'b10:   y <= {y[6:0], data_r};
            default: y <= y;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_S"},      32'(s),      32'h0);
        check({tag, "_data"},   32'(data),   32'h0);
        check({tag, "_L"},      32'(data_l), 32'h0);
        check({tag, "_R"},      32'(data_r), 32'h0);
        check({tag, "_busy"},   32'(busy),   32'h0);
        check({tag, "_done"},   32'(done),   32'h0);
        check({tag, "_result"}, 32'(result), 32'h0);
    endtask

    // Starts a job in the current (idle) cycle and returns in its done_o cycle.
    task automatic run_job(input vec_t v);
        int          n;
        bit          got;
        logic [1:0]  exp_s;
        logic        in_shift;
        n = v.exp_lat - 3;
        load_data = v.load;
        dir       = v.dir;
        count     = v.count;
        fill      = v.fill;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        load_data = ~v.load;
        dir       = ~v.dir;
        fill      = ~v.fill;
        count     = 4'd0;
        check("done_drop", 32'(done), 32'h0);
        got = 1'b0;
        for (int k = 1; k <= 20 && !got; k++) begin
            if (done) begin
                got = 1'b1;
                check("latency", 32'(k), 32'(v.exp_lat));
            end else begin
                in_shift = (k >= 2) && (k <= n + 1);
                exp_s = (k == 1) ? 2'b11 : (in_shift ? (v.dir ? 2'b01 : 2'b10) : 2'b00);
                check("S_seq",   32'(s),      32'(exp_s));
                check("busy_on", 32'(busy),   32'h1);
                check("data_L",  32'(data_l), 32'((in_shift && v.dir) ? v.fill : 1'b0));
                check("data_R",  32'(data_r), 32'((in_shift && !v.dir) ? v.fill : 1'b0));
                if (k == 1) check("load_data", 32'(data), 32'(v.load));
                tick();
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done expected done at %0d", v.exp_lat);
        end
        check("result",    32'(result), 32'(v.exp_result));
        check("busy_done", 32'(busy),   32'h0);
        check("S_done",    32'(s),      32'h0);
        check("data_hold", 32'(data),   32'(v.load));
    endtask

    initial begin
        vecs[0] = '{8'hB4, 1'b0, 4'd2,  1'b1, 8'hD3, 5};
        vecs[1] = '{8'hB4, 1'b1, 4'd3,  1'b0, 8'h16, 6};
        vecs[2] = '{8'h5A, 1'b0, 4'd0,  1'b0, 8'h5A, 3};
        vecs[3] = '{8'h00, 1'b1, 4'd12, 1'b1, 8'hFF, 11};
        vecs[4] = '{8'h81, 1'b0, 4'd1,  1'b0, 8'h02, 4};
        vecs[5] = '{8'h0F, 1'b1, 4'd4,  1'b1, 8'hF0, 7};

        rst = 1'b1;
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Back-to-back: each job after the first starts in the previous done_o cycle.
        for (int i = 0; i < 6; i++) run_job(vecs[i]);
        tick();
        check("done_single", 32'(done), 32'h0);
        check("result_hold", 32'(result), 32'hF0);

        // Abort in the 2nd SHIFT cycle; a start while busy must be dropped.
        load_data = 8'h33; dir = 1'b0; count = 4'd6; fill = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("abort_pre_S",    32'(s),    32'h2);
        check("abort_pre_busy", 32'(busy), 32'h1);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_S",    32'(s),    32'h0);
        for (int i = 0; i < 10; i++) begin
            check("abort_no_done", 32'(done), 32'h0);
            check("abort_idle",    32'(busy), 32'h0);
            tick();
        end
        check("abort_result", 32'(result), 32'hF0);

        // Abort while in LOAD.
        load_data = 8'hAA; count = 4'd3; start = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_load_busy", 32'(busy), 32'h0);
        tick();
        tick();
        check("abort_load_done",   32'(done),   32'h0);
        check("abort_load_result", 32'(result), 32'hF0);

        // Reset mid-SHIFT, with start and abort also high at the reset edge.
        load_data = 8'hC3; dir = 1'b1; count = 4'd5; fill = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("pre_reset_busy", 32'(busy), 32'h1);
        rst = 1'b1; start = 1'b1; abort = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        check_reset_outputs("midreset");
        tick();
        check("post_reset_idle", 32'(busy), 32'h0);
        for (int i = 0; i < 8; i++) begin
            check("post_reset_no_done", 32'(done), 32'h0);
            tick();
        end
        run_job(vecs[0]);
        tick();
        check("final_done_low", 32'(done), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have port Clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port Rst  input  1  reset; synchronous, active-high.
REQ-003 SHALL have port start_i  input  1  request one load-and-shift job.
REQ-004 SHALL have port abort_i  input  1  cancel the job in progress.
REQ-005 SHALL have port dir_i  input  1  shift direction: 0 = left, 1 = right.
REQ-006 SHALL have port count_i  input  4  number of single-bit shifts requested.
REQ-007 SHALL have port load_data_i  input  8  byte to parallel-load.
REQ-008 SHALL have port fill_i  input  1  serial bit shifted in at the vacated end.
REQ-009 SHALL have port Y_i  input  8  registered output of the controlled shifter.
REQ-010 SHALL have port S_o  output  2  shifter mode: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-011 SHALL have port data_o  output  8  shifter parallel-load data.
REQ-012 SHALL have port data_L_o  output  1  shifter left serial input, which enters bit 7 on a right shift.
REQ-013 SHALL have port data_R_o  output  1  shifter right serial input, which enters bit 0 on a left shift.
REQ-014 SHALL have port busy_o  output  1  job in progress.
REQ-015 SHALL have port done_o  output  1  one-cycle completion pulse.
REQ-016 SHALL have port result_o  output  8  final shifter value of the last completed job.

Function
REQ-017 SHALL implement the FSM states IDLE, LOAD, SHIFT and DONE, with the shifter updating on the same Clk edge.
REQ-018 SHALL, in IDLE with start_i=1 at an edge, capture load_data_i, dir_i, fill_i and eff_count = min(count_i, 8), then enter LOAD.
REQ-019 SHALL ignore start_i in every state other than IDLE, without queuing it.
REQ-020 SHALL drive, in LOAD, S_o=11 and data_o=captured byte, then go to SHIFT when eff_count>0, else DONE.
REQ-021 SHALL drive, in SHIFT, S_o=01 if dir=1 else 10, for exactly eff_count consecutive cycles, decrementing a 4-bit counter each cycle and entering DONE when it reaches 1 at an edge.
REQ-022 SHALL drive, during a right shift, data_L_o=captured fill with data_R_o=0, and during a left shift, data_R_o=captured fill with data_L_o=0; outside SHIFT both are 0.
REQ-023 SHALL drive, in DONE, S_o=00, and at the edge leaving DONE register result_o<=Y_i and done_o<=1, then go to IDLE.
REQ-024 SHALL hold done_o high for exactly one cycle per completed job; result_o SHALL hold its value until the next completion.
REQ-025 SHALL drive busy_o=1 in LOAD, SHIFT and DONE, and 0 in IDLE, including the done_o cycle.
REQ-026 SHALL accept a new start_i in the same cycle done_o is high.
REQ-027 SHALL give latency from a start-accepted edge E to done_o high of cycle E+eff_count+3, counting the cycle after E as cycle E+1.
REQ-028 SHALL, when abort_i=1 at an edge in LOAD or SHIFT, go to IDLE with S_o=00, no done_o and result_o unchanged; abort_i SHALL be ignored in IDLE and DONE.
REQ-029 SHALL give abort_i priority over start_i when both are high.
REQ-030 SHALL drive S_o=00 in IDLE.
REQ-031 SHALL keep data_o equal to the captured byte between jobs.

Reset
REQ-032 SHALL, with Rst=1 at an edge, force IDLE, counter=0, captured registers=0, S_o=00, data_o=0x00, data_L_o=0, data_R_o=0, busy_o=0, done_o=0 and result_o=0x00.
REQ-033 SHALL give Rst priority over start_i and abort_i, and SHALL abandon any job mid-operation without a done_o pulse.

Verification
REQ-034 SHALL verify: load 0xB4, dir=0, count=2, fill=1 -> S_o sequence 11,10,10,00; done_o at E+5; result_o=0xD3.
REQ-035 SHALL verify: load 0xB4, dir=1, count=3, fill=0 -> result_o=0x16; done_o at E+6; data_L_o=0 throughout.
REQ-036 SHALL verify: count=0, load 0x5A -> LOAD goes directly to DONE; done_o at E+3; result_o=0x5A.
REQ-037 SHALL verify: count=12, dir=1, fill=1, load 0x00 -> exactly 8 shift cycles; result_o=0xFF.
REQ-038 SHALL verify: abort_i in the 2nd SHIFT cycle of a count=6 job -> IDLE next cycle, no done_o, result_o unchanged; a start_i pulsed while busy is ignored.
REQ-039 SHALL verify: Rst asserted mid-SHIFT -> all outputs at reset values next cycle; a following job completes normally.
